// File: rtl/qcpu_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qcpu_uart_fifo
// Purpose  : TX/RX byte FIFOs between the QCPU I/O bus and the UART core,
//            with a start/busy launch sequencer and has_byte/clr_hb capture.
// Revision : 1.0 - initial release
// ============================================================================
module qcpu_uart_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic                  tx_idle,
  output logic [7:0]            rx_data,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  tx_ovf,
  output logic                  rx_udf,
  input  logic                  clr_err,
  output logic [7:0]            uart_din,
  output logic                  uart_start,
  input  logic                  uart_busy,
  input  logic [7:0]            uart_dout,
  input  logic                  uart_has_byte,
  output logic                  uart_clr_hb
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  tx_state_t        r_state;
  logic             r_uart_start;
  logic [7:0]       r_uart_din;
  logic             r_clr_hb;
  logic             r_tx_ovf;
  logic             r_rx_udf;

  logic [c_PW-1:0]  r_tx_wptr;
  logic [c_PW-1:0]  r_tx_rptr;
  logic [7:0]       r_tx_mem [c_DEPTH];
  logic [c_PW-1:0]  r_rx_wptr;
  logic [c_PW-1:0]  r_rx_rptr;
  logic [7:0]       r_rx_mem [c_DEPTH];

  logic             w_tx_empty;
  logic             w_tx_full;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_rx_empty;
  logic             w_rx_full;
  logic             w_rx_push;
  logic             w_rx_pop;

  // Full and empty are derived from pre-edge pointers only, so a same-cycle
  // pop never makes room for a write that arrives while full.
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[DEPTH_LOG2-1:0] == r_tx_rptr[DEPTH_LOG2-1:0]) &&
                      (r_tx_wptr[DEPTH_LOG2] != r_tx_rptr[DEPTH_LOG2]);
  assign w_tx_push  = tx_wr && !w_tx_full;
  assign w_tx_pop   = (r_state == S_IDLE) && !w_tx_empty;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[DEPTH_LOG2-1:0] == r_rx_rptr[DEPTH_LOG2-1:0]) &&
                      (r_rx_wptr[DEPTH_LOG2] != r_rx_rptr[DEPTH_LOG2]);
  // clr_hb high means the core still shows the byte just taken.
  assign w_rx_push  = uart_has_byte && !w_rx_full && !r_clr_hb;
  assign w_rx_pop   = rx_rd && !w_rx_empty;

  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[DEPTH_LOG2-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[DEPTH_LOG2-1:0]] <= uart_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_PW'(1);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_uart_start <= 1'b0;
      r_uart_din   <= 8'h00;
    end else begin
      r_uart_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_tx_empty) begin
            r_uart_din   <= r_tx_mem[r_tx_rptr[DEPTH_LOG2-1:0]];
            r_uart_start <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_BUSY;
        end
        // The core raises busy a couple of cycles after start; wait for it
        // so the next launch cannot overlap the frame in flight.
        S_WAIT_BUSY: begin
          if (uart_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!uart_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_hb <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_clr_hb <= w_rx_push;
      if (tx_wr && w_tx_full) begin
        r_tx_ovf <= 1'b1;
      end else if (clr_err) begin
        r_tx_ovf <= 1'b0;
      end
      if (rx_rd && w_rx_empty) begin
        r_rx_udf <= 1'b1;
      end else if (clr_err) begin
        r_rx_udf <= 1'b0;
      end
    end
  end

  assign tx_full     = w_tx_full;
  assign tx_level    = r_tx_wptr - r_tx_rptr;
  assign tx_idle     = w_tx_empty && (r_state == S_IDLE);
  assign rx_empty    = w_rx_empty;
  assign rx_level    = r_rx_wptr - r_rx_rptr;
  assign rx_data     = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[DEPTH_LOG2-1:0]];
  assign tx_ovf      = r_tx_ovf;
  assign rx_udf      = r_rx_udf;
  assign uart_din    = r_uart_din;
  assign uart_start  = r_uart_start;
  assign uart_clr_hb = r_clr_hb;

endmodule
`default_nettype wire

// File: tb/tb_qcpu_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_qcpu_uart_fifo
// Purpose  : Scoreboard bench for qcpu_uart_fifo with a simple UART core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qcpu_uart_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [3:0] tx_level;
  logic       tx_idle;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       rx_empty;
  logic [3:0] rx_level;
  logic       tx_ovf;
  logic       rx_udf;
  logic       clr_err;
  logic [7:0] uart_din;
  logic       uart_start;
  logic       uart_busy;
  logic [7:0] uart_dout;
  logic       uart_has_byte;
  logic       uart_clr_hb;

  int         tests = 0;
  int         fails = 0;
  int         n_starts = 0;
  int         n_clr = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       stall = 1'b0;
  logic       core_active = 1'b0;

  qcpu_uart_fifo #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_level(tx_level),
    .tx_idle(tx_idle), .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_level(rx_level), .tx_ovf(tx_ovf), .rx_udf(rx_udf), .clr_err(clr_err),
    .uart_din(uart_din), .uart_start(uart_start), .uart_busy(uart_busy),
    .uart_dout(uart_dout), .uart_has_byte(uart_has_byte), .uart_clr_hb(uart_clr_hb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART core model: busy rises 2 cycles after start is sampled, lasts 5 cycles.
  initial begin
    logic s_start, s_rst;
    int   cnt;
    uart_busy = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      s_start = uart_start;
      s_rst   = rst;
      #1;
      if (s_rst) begin
        uart_busy = 1'b0; core_active = 1'b0; cnt = 0;
      end else if (stall) begin
        uart_busy = 1'b1; cnt = 0;
        if (s_start) core_active = 1'b1;
      end else if (s_start) begin
        core_active = 1'b1; cnt = 0;
      end else if (core_active) begin
        cnt++;
        if (cnt == 2) uart_busy = 1'b1;
        if (cnt == 7) begin uart_busy = 1'b0; core_active = 1'b0; end
      end else begin
        uart_busy = 1'b0;
      end
    end
  end

  // Monitor: checks every launch and every RX dequeue against the scoreboard.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (uart_clr_hb === 1'b1) n_clr++;
      if (uart_start === 1'b1) begin
        n_starts++;
        chk("start_while_core_busy", {31'd0, core_active}, 32'd0);
        if (tx_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          exp = tx_q.pop_front();
          chk("uart_din", {24'd0, uart_din}, {24'd0, exp});
        end
      end
      if (rx_rd === 1'b1 && rx_empty === 1'b0) begin
        if (rx_q.size() == 0) begin
          chk("unexpected_rx_byte", 32'd1, 32'd0);
        end else begin
          exp = rx_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp});
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (tx_idle !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, tx_idle}, 32'd1);
  endtask

  task automatic rx_present(input logic [7:0] b);
    @(posedge clk); #1;
    uart_has_byte = 1'b1;
    uart_dout     = b;
    rx_q.push_back(b);
  endtask

  task automatic rx_wait_ack();
    logic s;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      s = uart_clr_hb;
      #1;
      if (s) begin
        uart_has_byte = 1'b0;
        return;
      end
    end
    chk("rx_ack_timeout", 32'd1, 32'd0);
    uart_has_byte = 1'b0;
  endtask

  task automatic rx_read();
    @(posedge clk); #1 rx_rd = 1'b1;
    @(posedge clk); #1 rx_rd = 1'b0;
  endtask

  initial begin
    int snap;
    rst = 1'b1; tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0; clr_err = 1'b0;
    uart_dout = 8'h00; uart_has_byte = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
    chk("rst_tx_level", {28'd0, tx_level}, 32'd0);
    chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
    chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_outs", {28'd0, uart_start, uart_clr_hb, tx_ovf, rx_udf}, 32'd0);
    chk("rst_uart_din", {24'd0, uart_din}, 32'd0);

    // Two bytes back-to-back: the second push coincides with the first pop.
    @(posedge clk); #1 tx_wr = 1'b1; tx_data = 8'h55; tx_q.push_back(8'h55);
    @(posedge clk); #1 tx_data = 8'hA3; tx_q.push_back(8'hA3);
    chk("tx_level_after_1", {28'd0, tx_level}, 32'd1);
    chk("tx_idle_falls", {31'd0, tx_idle}, 32'd0);
    @(posedge clk); #1 tx_wr = 1'b0;
    @(negedge clk);
    chk("tx_level_push_pop", {28'd0, tx_level}, 32'd1);
    wait_idle("tx_idle_after_2", 200);
    chk("two_starts", n_starts, 32'd2);

    // Overflow with the sequencer parked in WAIT_DONE.
    stall = 1'b1;
    @(posedge clk); #1 tx_wr = 1'b1; tx_data = 8'h11; tx_q.push_back(8'h11);
    @(posedge clk); #1 tx_wr = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin
        chk("tx_full_at_8", {31'd0, tx_full}, 32'd1);
        chk("tx_level_8", {28'd0, tx_level}, 32'd8);
      end
      tx_wr = 1'b1;
      tx_data = 8'h20 + 8'(i);
      if (i < 8) tx_q.push_back(8'h20 + 8'(i));
    end
    @(posedge clk); #1 tx_wr = 1'b0;
    @(negedge clk);
    chk("tx_ovf_set", {31'd0, tx_ovf}, 32'd1);
    chk("tx_level_still_8", {28'd0, tx_level}, 32'd8);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    chk("tx_ovf_cleared", {31'd0, tx_ovf}, 32'd0);
    stall = 1'b0;
    wait_idle("tx_drain_idle", 400);
    chk("tx_q_drained", tx_q.size(), 32'd0);

    // Single RX byte.
    snap = n_clr;
    rx_present(8'h3C);
    rx_wait_ack();
    @(negedge clk);
    chk("rx_one_clr", n_clr - snap, 32'd1);
    chk("rx_level_1", {28'd0, rx_level}, 32'd1);
    chk("rx_data_3c", {24'd0, rx_data}, 32'h3C);
    rx_read();
    @(negedge clk);
    chk("rx_empty_after_rd", {31'd0, rx_empty}, 32'd1);

    // Fill RX; a ninth byte waits in the core until space frees.
    for (int i = 0; i < 8; i++) begin
      rx_present(8'h80 + 8'(i));
      rx_wait_ack();
    end
    snap = n_clr;
    rx_present(8'h90);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rx_full_no_clr", n_clr - snap, 32'd0);
    chk("rx_level_full", {28'd0, rx_level}, 32'd8);
    rx_read();
    rx_wait_ack();
    @(negedge clk);
    chk("rx_resume_clr", n_clr - snap, 32'd1);
    chk("rx_level_back_8", {28'd0, rx_level}, 32'd8);
    for (int i = 0; i < 8; i++) rx_read();
    @(negedge clk);
    chk("rx_drained", {31'd0, rx_empty}, 32'd1);
    chk("rx_q_drained", rx_q.size(), 32'd0);

    // Underflow, and error beating a same-cycle clear.
    rx_read();
    @(negedge clk);
    chk("rx_udf_set", {31'd0, rx_udf}, 32'd1);
    chk("rx_level_unchanged", {28'd0, rx_level}, 32'd0);
    @(posedge clk); #1 clr_err = 1'b1; rx_rd = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0; rx_rd = 1'b0;
    @(negedge clk);
    chk("rx_udf_err_wins", {31'd0, rx_udf}, 32'd1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    chk("rx_udf_cleared", {31'd0, rx_udf}, 32'd0);

    // Reset while in WAIT_DONE with three bytes still queued.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 tx_wr = 1'b1; tx_data = 8'h70 + 8'(i);
      if (i == 0) tx_q.push_back(8'h70);
    end
    @(posedge clk); #1 tx_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tx_level_3_queued", {28'd0, tx_level}, 32'd3);
    snap = n_starts;
    @(posedge clk); #1 rst = 1'b1; stall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_tx_level", {28'd0, tx_level}, 32'd0);
    chk("rst2_tx_idle", {31'd0, tx_idle}, 32'd1);
    chk("rst2_outs", {28'd0, uart_start, uart_clr_hb, tx_ovf, rx_udf}, 32'd0);
    chk("rst2_uart_din", {24'd0, uart_din}, 32'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("rst2_no_more_starts", n_starts - snap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/qcpu_uart_fifo.md
# qcpu_uart_fifo

Byte-buffering stage between the QCPU I/O bus and the UART serial core. Holds up to 2^DEPTH_LOG2 bytes queued for transmit, feeds them one at a time to the core's start/busy handshake, and drains received bytes from the core's has_byte/clr_hb handshake into a receive queue the CPU reads at its own pace.

## Interface
- DEPTH_LOG2, 3, log2 of each FIFO depth (TX and RX identical; 8 entries by default)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to enqueue for transmit
- tx_wr  in  1  enqueue strobe, one byte per cycle
- tx_full  out  1  TX FIFO holds 2^DEPTH_LOG2 bytes
- tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy
- tx_idle  out  1  TX FIFO empty and sequencer in IDLE
- rx_data  out  8  head of RX FIFO (show-ahead); 0 when empty
- rx_rd  in  1  dequeue strobe
- rx_empty  out  1  RX FIFO empty
- rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy
- tx_ovf  out  1  sticky: tx_wr while full
- rx_udf  out  1  sticky: rx_rd while empty
- clr_err  in  1  clears tx_ovf and rx_udf
- uart_din  out  8  byte presented to core
- uart_start  out  1  one-cycle launch pulse to core
- uart_busy  in  1  core transmitting
- uart_dout  in  8  core's received byte
- uart_has_byte  in  1  core holds an unread byte
- uart_clr_hb  out  1  one-cycle acknowledge to core

## Operation
- Both FIFOs: circular buffers, pointers DEPTH_LOG2+1 bits wide (extra wrap bit); full = indices equal and wrap bits differ; empty = pointers equal; level = wptr − rptr mod 2^(DEPTH_LOG2+1).
- Full/empty evaluated on pre-edge state: tx_wr while full is dropped and sets tx_ovf even if a pop occurs the same cycle; rx_rd while empty is ignored and sets rx_udf.
- clr_err and a new error event in the same cycle: error wins (flag stays 1).
- TX sequencer states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if TX FIFO non-empty → LAUNCH; register uart_din = head, pop head, uart_start = 1.
  - LAUNCH: uart_start = 0 → WAIT_BUSY.
  - WAIT_BUSY: stay until uart_busy = 1 → WAIT_DONE.
  - WAIT_DONE: stay until uart_busy = 0 → IDLE.
- uart_din holds its value until the next launch.
- RX capture: when uart_has_byte = 1, RX FIFO not full and uart_clr_hb = 0, push uart_dout and register uart_clr_hb = 1 for exactly one cycle. uart_clr_hb being high blocks re-capture of the same byte.
- RX FIFO full: no capture and no acknowledge. The byte remains in the core until space frees.
- Simultaneous push and pop on either FIFO: both take effect, level unchanged. Pop of the last entry plus push in the same cycle is legal.

## Timing
- Reset: all pointers 0; sequencer IDLE; uart_start, uart_clr_hb, uart_din, tx_ovf, rx_udf = 0; tx_full = 0; tx_level = rx_level = 0; tx_idle = 1; rx_empty = 1; rx_data = 0.
- rst mid-frame aborts the sequencer and discards both FIFOs; the core is reset by the same rst.
- tx_wr at edge N: tx_level increments and tx_idle falls after N.
- From IDLE with data present, uart_start rises in the cycle after edge N+1 (registered). At that edge the core loads the byte.
- The core raises busy 2 cycles after sampling start. WAIT_BUSY absorbs this, so the next uart_start is never issued before the previous frame completes.
- Back-to-back bytes: minimum 2 idle cycles between busy falling and the next busy rising.
- RX: has_byte seen in cycle C → push at edge C, clr_hb high in cycle C+1, has_byte low from C+2. The byte is readable on rx_data in cycle C+1.
- rx_rd at edge N: rx_data shows the next entry after N.

## Test plan
- Reset then write 0x55, 0xA3: exactly two uart_start pulses with uart_din 0x55 then 0xA3; each pulse occurs only after the previous busy has fallen; tx_idle returns to 1.
- Write 9 bytes with DEPTH_LOG2 = 3 and the sequencer stalled (busy held 1): tx_full = 1 at 8, the 9th is dropped, tx_ovf = 1, tx_level = 8; clr_err clears tx_ovf.
- Core model raises has_byte with dout 0x3C: one uart_clr_hb pulse, rx_level = 1, rx_data = 0x3C; rx_rd → rx_empty = 1.
- Fill RX to 8 with has_byte still asserted: no clr_hb issued; one rx_rd → capture resumes the next cycle, level back to 8.
- rx_rd on empty → rx_udf = 1, pointers unchanged. Simultaneous tx_wr and launch pop at level 1 → level stays 1.
- Assert rst during WAIT_DONE with 3 bytes queued: all outputs at reset values the next cycle, no further uart_start.
